// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: synchronizes the emulated PS/2 pair, deserializes 11-bit frames
// and decodes scancode-set-2 prefixes (E0, F0, E1 pause) into one-cycle key events.
module ps2_kbd_decoder #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_kbd_clk,
   input  logic       ps2_kbd_data,
   output logic       key_strobe,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_pressed,
   output logic       key_pause,
   output logic       rx_err,
   output logic       rx_busy
);

   localparam int unsigned WDW = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_e;

   rx_state_e      state_q, state_d;
   logic [2:0]     clk_sync_q;
   logic [1:0]     dat_sync_q;
   logic           fall_q;
   logic           bit_q;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     bitcnt_q, bitcnt_d;
   logic           par_q, par_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           ext_q, ext_d;
   logic           rel_q, rel_d;
   logic [2:0]     skip_q, skip_d;
   logic           strobe_q, strobe_d;
   logic           pause_q, pause_d;
   logic           err_q, err_d;
   logic [7:0]     code_q, code_d;
   logic           kext_q, kext_d;
   logic           kpr_q, kpr_d;
   logic           byte_ok;

   // The data bit is registered alongside the edge flag so both reach the FSM on the same cycle.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         fall_q     <= 1'b0;
         bit_q      <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], ps2_kbd_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_kbd_data};
         fall_q     <= clk_sync_q[2] & ~clk_sync_q[1];
         bit_q      <= dat_sync_q[1];
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bitcnt_q <= '0;
         par_q    <= 1'b0;
         wd_q     <= '0;
         ext_q    <= 1'b0;
         rel_q    <= 1'b0;
         skip_q   <= '0;
         strobe_q <= 1'b0;
         pause_q  <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= '0;
         kext_q   <= 1'b0;
         kpr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         par_q    <= par_d;
         wd_q     <= wd_d;
         ext_q    <= ext_d;
         rel_q    <= rel_d;
         skip_q   <= skip_d;
         strobe_q <= strobe_d;
         pause_q  <= pause_d;
         err_q    <= err_d;
         code_q   <= code_d;
         kext_q   <= kext_d;
         kpr_q    <= kpr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      par_d    = par_q;
      wd_d     = wd_q;
      ext_d    = ext_q;
      rel_d    = rel_q;
      skip_d   = skip_q;
      strobe_d = 1'b0;
      pause_d  = 1'b0;
      err_d    = 1'b0;
      code_d   = code_q;
      kext_d   = kext_q;
      kpr_d    = kpr_q;
      byte_ok  = 1'b0;

      // A frame edge takes priority over watchdog expiry on the same cycle.
      if (fall_q) begin
         wd_d = '0;
         case (state_q)
            S_IDLE: begin
               if (!bit_q) begin
                  shift_d  = '0;
                  bitcnt_d = '0;
                  state_d  = S_DATA;
               end
            end
            S_DATA: begin
               shift_d  = {bit_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = bit_q;
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if ((^{shift_q, par_q}) && bit_q) byte_ok = 1'b1;
               else                              err_d   = 1'b1;
            end
         endcase
      end else if (state_q != S_IDLE) begin
         if (wd_q == WD_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            wd_d    = '0;
         end else begin
            wd_d = wd_q + WDW'(1);
         end
      end else begin
         wd_d = '0;
      end

      if (err_d) begin
         ext_d  = 1'b0;
         rel_d  = 1'b0;
         skip_d = '0;
      end else if (byte_ok) begin
         if (skip_q != 3'd0) begin
            skip_d  = skip_q - 3'd1;
            pause_d = (skip_q == 3'd1);
         end else if (shift_q == 8'hE1) begin
            skip_d = 3'd7;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            rel_d = 1'b1;
         end else begin
            strobe_d = 1'b1;
            code_d   = shift_q;
            kext_d   = ext_q;
            kpr_d    = ~rel_q;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
         end
      end
   end

   assign key_strobe  = strobe_q;
   assign key_code    = code_q;
   assign key_ext     = kext_q;
   assign key_pressed = kpr_q;
   assign key_pause   = pause_q;
   assign rx_err      = err_q;
   assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: table-driven frames, hand-written corner
// sequences and a randomized byte stream compared against a byte-level event model.
module tb_ps2_kbd_decoder;

   localparam int unsigned TO = 100;
   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pc = 1'b1;
   logic       pd = 1'b1;
   logic       key_strobe, key_ext, key_pressed, key_pause, rx_err, rx_busy;
   logic [7:0] key_code;

   ps2_kbd_decoder #(.TIMEOUT(TO)) dut (
      .clk_sys     (clk),
      .reset       (rst),
      .ps2_kbd_clk (pc),
      .ps2_kbd_data(pd),
      .key_strobe  (key_strobe),
      .key_code    (key_code),
      .key_ext     (key_ext),
      .key_pressed (key_pressed),
      .key_pause   (key_pause),
      .rx_err      (rx_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int         kind;   // 1 strobe, 2 pause, 3 error
      logic [7:0] code;
      logic       ext;
      logic       pr;
      int         at;
   } ev_t;
   ev_t evq[$];

   always @(posedge clk) begin
      #1;
      if (key_strobe) evq.push_back('{1, key_code, key_ext, key_pressed, cyc});
      if (key_pause)  evq.push_back('{2, key_code, key_ext, key_pressed, cyc});
      if (rx_err)     evq.push_back('{3, key_code, key_ext, key_pressed, cyc});
   end

   int n_chk = 0;
   int n_pass = 0;
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   int last_fall;
   task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
      logic [10:0] fr;
      fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) pd = fr[i];
         repeat (H - 1) @(negedge clk);
         pc = 1'b0;
         last_fall = cyc;
         repeat (H) @(negedge clk);
         pc = 1'b1;
      end
      pd = 1'b1;
   endtask

   task automatic expect_frame(input string nm, input int kind, input logic [7:0] code,
                               input bit ext, input bit pr);
      ev_t e;
      repeat (2) @(negedge clk);
      chk({nm, "_count"}, evq.size(), (kind != 0) ? 1 : 0);
      if (kind != 0 && evq.size() > 0) begin
         e = evq.pop_front();
         chk({nm, "_kind"}, e.kind, kind);
         chk({nm, "_latency"}, e.at - last_fall, 4);
         if (kind == 1) begin
            chk({nm, "_code"}, e.code, code);
            chk({nm, "_ext"}, e.ext, ext);
            chk({nm, "_pressed"}, e.pr, pr);
         end
      end
      evq.delete();
      chk({nm, "_busy"}, rx_busy, 0);
   endtask

   // Byte-level reference: prefix flags and pause skip count applied per received byte.
   int m_ext, m_rel, m_skip;
   task automatic model(input logic [7:0] b, input bit bad, output int kind,
                        output logic [7:0] code, output bit ext, output bit pr);
      kind = 0; code = b; ext = 0; pr = 0;
      if (bad) begin
         kind = 3; m_ext = 0; m_rel = 0; m_skip = 0;
      end else if (m_skip > 0) begin
         m_skip--;
         if (m_skip == 0) kind = 2;
      end else if (b == 8'hE1) begin
         m_skip = 7; m_ext = 0; m_rel = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_rel = 1;
      end else begin
         kind = 1; ext = (m_ext != 0); pr = (m_rel == 0);
         m_ext = 0; m_rel = 0;
      end
   endtask

   typedef struct {
      logic [7:0] b;
      bit         bp;
      bit         bs;
      int         kind;
      logic [7:0] code;
      bit         ext;
      bit         pr;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [7:0] b, input bit bp, input bit bs, input int kind,
                      input logic [7:0] code, input bit ext, input bit pr);
      tbl.push_back('{b, bp, bs, kind, code, ext, pr});
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_strobe"}, key_strobe, 0);
      chk({nm, "_pause"}, key_pause, 0);
      chk({nm, "_err"}, rx_err, 0);
      chk({nm, "_busy"}, rx_busy, 0);
      chk({nm, "_code"}, key_code, 0);
      chk({nm, "_ext"}, key_ext, 0);
      chk({nm, "_pressed"}, key_pressed, 0);
   endtask

   initial begin
      int         kind;
      logic [7:0] code, b;
      bit         ext, pr, bad;
      ev_t        e;
      int         lf;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_reset_quiet", evq.size(), 0);

      add(8'h1C, 0, 0, 1, 8'h1C, 0, 1);
      add(8'hE0, 0, 0, 0, 0, 0, 0);
      add(8'hF0, 0, 0, 0, 0, 0, 0);
      add(8'h75, 0, 0, 1, 8'h75, 1, 0);
      add(8'h77, 1, 0, 3, 0, 0, 0);
      add(8'h1C, 0, 0, 1, 8'h1C, 0, 1);
      add(8'hE1, 0, 0, 0, 0, 0, 0);
      add(8'h14, 0, 0, 0, 0, 0, 0);
      add(8'h77, 0, 0, 0, 0, 0, 0);
      add(8'hE1, 0, 0, 0, 0, 0, 0);
      add(8'hF0, 0, 0, 0, 0, 0, 0);
      add(8'h14, 0, 0, 0, 0, 0, 0);
      add(8'hF0, 0, 0, 0, 0, 0, 0);
      add(8'h77, 0, 0, 2, 0, 0, 0);
      add(8'h1C, 0, 1, 3, 0, 0, 0);
      add(8'hE0, 0, 0, 0, 0, 0, 0);
      add(8'hF0, 0, 0, 0, 0, 0, 0);
      add(8'hF0, 0, 0, 0, 0, 0, 0);
      add(8'h12, 0, 0, 1, 8'h12, 1, 0);
      add(8'hF0, 0, 0, 0, 0, 0, 0);
      add(8'hE0, 0, 0, 0, 0, 0, 0);
      add(8'h6B, 0, 0, 1, 8'h6B, 1, 0);
      add(8'hE0, 0, 0, 0, 0, 0, 0);
      add(8'h77, 1, 0, 3, 0, 0, 0);
      add(8'h1C, 0, 0, 1, 8'h1C, 0, 1);
      add(8'hE1, 0, 0, 0, 0, 0, 0);
      add(8'h14, 1, 0, 3, 0, 0, 0);
      add(8'h14, 0, 0, 1, 8'h14, 0, 1);

      foreach (tbl[i]) begin
         send_bits(tbl[i].b, tbl[i].bp, tbl[i].bs, 11);
         expect_frame($sformatf("vec%0d", i), tbl[i].kind, tbl[i].code, tbl[i].ext, tbl[i].pr);
      end

      // Watchdog: start bit plus four data bits, then the PS/2 clock stops.
      send_bits(8'h5A, 0, 0, 5);
      lf = last_fall;
      chk("wd_busy_mid", rx_busy, 1);
      for (int i = 0; i < 300 && evq.size() == 0; i++) @(negedge clk);
      chk("wd_count", evq.size(), 1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         chk("wd_kind", e.kind, 3);
         chk("wd_latency", e.at - lf, 4 + TO + 1);
      end
      repeat (2) @(negedge clk);
      chk("wd_busy_after", rx_busy, 0);
      chk("wd_hold_code", key_code, 8'h14);
      evq.delete();
      send_bits(8'h29, 0, 0, 11);
      expect_frame("wd_next", 1, 8'h29, 0, 1);

      // Reset in the middle of a frame that follows a break prefix.
      send_bits(8'hF0, 0, 0, 11);
      expect_frame("rst_f0", 0, 0, 0, 0);
      send_bits(8'h1C, 0, 0, 4);
      chk("rst_busy_mid", rx_busy, 1);
      @(negedge clk) rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk) rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_quiet", evq.size(), 0);
      evq.delete();
      send_bits(8'h1C, 0, 0, 11);
      expect_frame("rst_next", 1, 8'h1C, 0, 1);

      m_ext = 0; m_rel = 0; m_skip = 0;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h14;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bad = ($urandom_range(0, 9) == 0);
         model(b, bad, kind, code, ext, pr);
         send_bits(b, bad && ($urandom_range(0, 1) == 0), 1'b0, 0);
         if (bad) begin
            if ($urandom_range(0, 1) == 0) send_bits(b, 1, 0, 11);
            else                           send_bits(b, 0, 1, 11);
         end else begin
            send_bits(b, 0, 0, 11);
         end
         expect_frame($sformatf("rnd%0d", n), kind, code, ext, pr);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_decoder.md
# ps2_kbd_decoder

Consumes the emulated PS/2 keyboard pair (`ps2_kbd_clk`, `ps2_kbd_data`) driven by the MiST I/O block and turns it into one-cycle key events for the core's keyboard matrix logic. The block has three stages: an 11-bit frame deserializer, a parity/stop checker with a watchdog, and a scancode-set-2 prefix decoder for E0, F0 and the E1 pause sequence. It runs entirely in `clk_sys` and sits directly downstream of the I/O block's PS/2 transmitter.

## Interface
- `TIMEOUT`, default 1000: `clk_sys` cycles allowed between consecutive PS/2 clock falling edges inside a frame. Must exceed one PS/2 bit period, which is `2*(PS2DIV+1)` cycles.
- `clk_sys` in, 1: system clock. All logic runs on the rising edge.
- `reset` in, 1: asynchronous, active-high. Clears all state and outputs.
- `ps2_kbd_clk` in, 1: PS/2 clock. Idles high. Data is sampled on its falling edge.
- `ps2_kbd_data` in, 1: PS/2 data. Frame is start(0), d0..d7 (LSB first), odd parity, stop(1).
- `key_strobe` out, 1: one-cycle pulse; the key event fields below are valid on that cycle.
- `key_code` out, 8: scancode of the event.
- `key_ext` out, 1: an E0 prefix preceded the code.
- `key_pressed` out, 1: 1 = make, 0 = break (an F0 prefix preceded the code).
- `key_pause` out, 1: one-cycle pulse when a complete E1 pause sequence has been received.
- `rx_err` out, 1: one-cycle pulse on a parity error, stop-bit error or watchdog timeout.
- `rx_busy` out, 1: high while a frame is being received (from start bit to completion or abort).

## Operation
- Input conditioning
  - Both inputs pass through 2-flop synchronizers.
  - A third flop on the clock path provides edge detection.
  - A falling edge is synchronized clk previous = 1, current = 0.
- Deserializer states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data = 0, clear the shift register, go to DATA, assert `rx_busy`. Data = 1 is ignored with no error.
  - DATA: shift data into bit[7] and shift right, 8 edges, then go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on the edge, check `^{data, parity} == 1` and stop == 1.
    - Pass: deliver the byte to the decoder.
    - Fail: pulse `rx_err`.
    - Either way, return to IDLE.
- Watchdog
  - Counter cleared on every falling edge; counts while not IDLE.
  - At `TIMEOUT` it pulses `rx_err` and forces IDLE.
  - Counter width is `$clog2(TIMEOUT+1)`; it never wraps.
- Decoder (runs on each valid byte)
  - Pause skip count nonzero: decrement it. If it reaches 0, pulse `key_pause`. No other event; prefix flags untouched.
  - Byte E1: load the skip count with 7. Clear `ext` and `rel`.
  - Byte E0: set `ext`.
  - Byte F0: set `rel`.
  - Any other byte: pulse `key_strobe` with `key_code` = byte, `key_ext` = ext, `key_pressed` = !rel. Then clear `ext` and `rel`.
- Any `rx_err` clears `ext`, `rel` and the skip count.
- The prefix order E0 F0 and a repeated F0 are both accepted; each flag is sticky until the next non-prefix byte.

## Timing
- Reset values:
  - `key_strobe`, `key_pause`, `rx_err`, `rx_busy` = 0.
  - `key_code` = 0x00, `key_ext` = 0, `key_pressed` = 0.
  - Deserializer in IDLE; watchdog, `ext`, `rel` and skip count = 0.
- Latency: `key_strobe`/`key_pause`/`rx_err` (parity or stop error) rise exactly 4 `clk_sys` cycles after the stop-bit falling edge of `ps2_kbd_clk` at the port. That is 2 synchronizer cycles, 1 edge-detect cycle and 1 output register cycle.
- Pulse widths: `key_strobe`, `key_pause` and `rx_err` are high for exactly 1 cycle.
- Held outputs: `key_code`, `key_ext` and `key_pressed` hold their values until the next `key_strobe`.
- `rx_busy` falls on the same cycle the result pulse rises.
- Timeout: `rx_err` rises `TIMEOUT`+1 cycles after the last in-frame edge was detected.
- A frame edge coinciding with the watchdog expiry: the edge wins and the counter clears.
- Back-to-back frames with no idle gap are accepted. A start bit may arrive on the edge immediately after the stop bit.
- `reset` mid-frame discards the partial byte and pending prefixes. No pulse is generated on deassertion.

## Test plan
- Make "A": frame 0x1C with parity 0, stop 1 → one `key_strobe` with `key_code` = 0x1C, `key_ext` = 0, `key_pressed` = 1, 4 cycles after the stop edge.
- Extended break: bytes E0, F0, 75 → exactly one `key_strobe` with `key_code` = 0x75, `key_ext` = 1, `key_pressed` = 0; no strobe for the E0 or F0 bytes.
- Parity error: 0x77 sent with parity 0 → `rx_err` pulse, no `key_strobe`. A following valid 0x1C is reported with `key_ext` = 0 and `key_pressed` = 1.
- Pause: E1 14 77 E1 F0 14 F0 77 → a single `key_pause` after the 8th byte, and no `key_strobe` at all.
- Watchdog: `TIMEOUT` = 100; stop the PS/2 clock after 5 bits → `rx_err` at 101 cycles and `rx_busy` = 0. The next full frame 0x29 decodes correctly.
- Reset mid-frame after F0 plus 4 bits: assert `reset` → all outputs 0. Then 0x1C → `key_pressed` = 1 (the F0 is forgotten).
